// File: rtl/hdmi_pll_cfg_pkg.sv
// Shared definitions for the HDMI pixel-PLL reconfiguration sequencer: register map,
// FSM encoding, counter-word layout and the write-table helpers.
package hdmi_pll_cfg_pkg;

  localparam logic [5:0] REG_MODE  = 6'h00;
  localparam logic [5:0] REG_START = 6'h02;
  localparam logic [5:0] REG_N     = 6'h03;
  localparam logic [5:0] REG_M     = 6'h04;
  localparam logic [5:0] REG_C     = 6'h05;
  localparam logic [5:0] REG_K     = 6'h07;
  localparam logic [5:0] REG_BW    = 6'h08;
  localparam logic [5:0] REG_CP    = 6'h09;

  localparam int LO_LSB   = 0;
  localparam int HI_LSB   = 8;
  localparam int BYP_BIT  = 16;
  localparam int ODD_BIT  = 17;
  localparam int CSEL_LSB = 18;

  localparam logic [4:0] CSEL_C0  = 5'd0;
  localparam logic [2:0] TBL_LAST = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR         = 3'd1,
    ST_VERIFY     = 3'd2,
    ST_START      = 3'd3,
    ST_WAIT_START = 3'd4,
    ST_WAIT_LOCK  = 3'd5,
    ST_DONE       = 3'd6,
    ST_ERR        = 3'd7
  } state_e;

  typedef struct packed {
    logic [7:0]  m_hi;
    logic [7:0]  m_lo;
    logic [7:0]  n_hi;
    logic [7:0]  n_lo;
    logic        n_byp;
    logic [7:0]  c_hi;
    logic [7:0]  c_lo;
    logic        c_odd;
    logic [31:0] k;
    logic [3:0]  bw;
    logic [2:0]  cp;
  } cfg_t;

  function automatic logic [31:0] cnt_word(input logic [7:0] hi, input logic [7:0] lo,
                                           input logic byp, input logic odd,
                                           input logic [4:0] csel);
    logic [31:0] w;
    w = 32'd0;
    w[LO_LSB +: 8]   = lo;
    w[HI_LSB +: 8]   = hi;
    w[BYP_BIT]       = byp;
    w[ODD_BIT]       = odd;
    w[CSEL_LSB +: 5] = csel;
    return w;
  endfunction

  function automatic logic [5:0] tbl_addr(input logic [2:0] idx);
    logic [5:0] a;
    case (idx)
      3'd0:    a = REG_MODE;
      3'd1:    a = REG_N;
      3'd2:    a = REG_M;
      3'd3:    a = REG_C;
      3'd4:    a = REG_K;
      3'd5:    a = REG_BW;
      3'd6:    a = REG_CP;
      default: a = REG_MODE;
    endcase
    return a;
  endfunction

  // Entry 0 writes 0 to MODE, which selects waitrequest mode in the reconfig core.
  function automatic logic [31:0] tbl_data(input logic [2:0] idx, input cfg_t c);
    logic [31:0] d;
    case (idx)
      3'd1:    d = cnt_word(c.n_hi, c.n_lo, c.n_byp, 1'b0, 5'd0);
      3'd2:    d = cnt_word(c.m_hi, c.m_lo, 1'b0, 1'b0, 5'd0);
      3'd3:    d = cnt_word(c.c_hi, c.c_lo, 1'b0, c.c_odd, CSEL_C0);
      3'd4:    d = c.k;
      3'd5:    d = {28'd0, c.bw};
      3'd6:    d = {29'd0, c.cp};
      default: d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hdmi_pll_cfg_seq_timer.sv
// Loadable 24-bit saturating up counter; expired is high once LIMIT cycles have elapsed
// since the last load (count LIMIT-1 reached), used for both reconfiguration waits.
module pll_cfg_timer #(
  parameter logic [23:0] LIMIT = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        en,
  output logic        expired
);

  logic [23:0] cnt_d, cnt_q;

  // Next count: load wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 24'hFF_FFFF)) begin
      cnt_d = cnt_q + 24'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= (LIMIT - 24'd1));

endmodule

// File: rtl/hdmi_pll_cfg_seq.sv
// HDMI pixel-PLL reconfiguration master (Avalon-MM, waitrequest mode).
// Optional readback check of the written table is enabled by defining PLL_CFG_VERIFY_EN.
module hdmi_pll_cfg_seq
  import hdmi_pll_cfg_pkg::*;
#(
  parameter logic [23:0] LOCK_TO     = 24'd5_000_000,
  parameter int          LOCK_STABLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [7:0]  cfg_m_hi,
  input  logic [7:0]  cfg_m_lo,
  input  logic [7:0]  cfg_n_hi,
  input  logic [7:0]  cfg_n_lo,
  input  logic        cfg_n_byp,
  input  logic [7:0]  cfg_c_hi,
  input  logic [7:0]  cfg_c_lo,
  input  logic        cfg_c_odd,
  input  logic [31:0] cfg_k,
  input  logic [3:0]  cfg_bw,
  input  logic [2:0]  cfg_cp,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [23:0] STAB_LAST = 24'(LOCK_STABLE - 1);

  state_e      state_d, state_q;
  logic [2:0]  idx_d, idx_q;
  logic [23:0] stab_d, stab_q;
  cfg_t        cfg_d, cfg_q, cfg_in_s;
  logic [5:0]  addr_d, addr_q;
  logic [31:0] wdata_d, wdata_q;
  logic        write_d, write_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        err_d, err_q;
  logic        start_run_s, lock_run_s, start_exp_s, lock_exp_s;

  assign cfg_in_s = '{m_hi: cfg_m_hi, m_lo: cfg_m_lo, n_hi: cfg_n_hi, n_lo: cfg_n_lo,
                      n_byp: cfg_n_byp, c_hi: cfg_c_hi, c_lo: cfg_c_lo, c_odd: cfg_c_odd,
                      k: cfg_k, bw: cfg_bw, cp: cfg_cp};

  assign start_run_s = (state_q == ST_START) || (state_q == ST_WAIT_START);
  assign lock_run_s  = (state_q == ST_WAIT_LOCK);

  pll_cfg_timer #(.LIMIT(LOCK_TO)) u_start_tmr (
    .clk(clk), .rst(rst), .load(!start_run_s), .load_val(24'd0), .en(start_run_s),
    .expired(start_exp_s)
  );

  pll_cfg_timer #(.LIMIT(LOCK_TO)) u_lock_tmr (
    .clk(clk), .rst(rst), .load(!lock_run_s), .load_val(24'd0), .en(lock_run_s),
    .expired(lock_exp_s)
  );

`ifdef PLL_CFG_VERIFY_EN
  logic read_d, read_q;
  assign mgmt_read = read_q;
`else
  logic unused_rdata_s;
  assign unused_rdata_s = ^mgmt_readdata;
  assign mgmt_read      = 1'b0;
`endif

  // Sequencer next-state and next-output logic; bus outputs are held while waitrequest is high.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stab_d  = stab_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef PLL_CFG_VERIFY_EN
    read_d  = read_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          cfg_d   = cfg_in_s;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          addr_d  = tbl_addr(3'd0);
          wdata_d = tbl_data(3'd0, cfg_in_s);
          write_d = 1'b1;
          state_d = ST_WR;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_WR: begin
        if (!mgmt_waitrequest) begin
          if (idx_q == TBL_LAST) begin
`ifdef PLL_CFG_VERIFY_EN
            write_d = 1'b0;
            read_d  = 1'b1;
            idx_d   = 3'd1;
            addr_d  = tbl_addr(3'd1);
            wdata_d = 32'd0;
            state_d = ST_VERIFY;
`else
            addr_d  = REG_START;
            wdata_d = 32'd0;
            state_d = ST_START;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            addr_d  = tbl_addr(idx_q + 3'd1);
            wdata_d = tbl_data(idx_q + 3'd1, cfg_q);
          end
        end else begin
          write_d = 1'b1;
        end
      end
`ifdef PLL_CFG_VERIFY_EN
      ST_VERIFY: begin
        if (!mgmt_waitrequest) begin
          if (mgmt_readdata != tbl_data(idx_q, cfg_q)) begin
            read_d  = 1'b0;
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else if (idx_q == TBL_LAST) begin
            read_d  = 1'b0;
            write_d = 1'b1;
            addr_d  = REG_START;
            wdata_d = 32'd0;
            state_d = ST_START;
          end else begin
            idx_d  = idx_q + 3'd1;
            addr_d = tbl_addr(idx_q + 3'd1);
          end
        end else begin
          read_d = 1'b1;
        end
      end
`endif
      ST_START, ST_WAIT_START: begin
        // The core holds waitrequest for the whole reconfiguration, so completion means done.
        if (!mgmt_waitrequest) begin
          write_d = 1'b0;
          stab_d  = 24'd0;
          state_d = ST_WAIT_LOCK;
        end else if (start_exp_s) begin
          write_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_LOCK: begin
        if (pll_locked && (stab_q == STAB_LAST)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (lock_exp_s) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          stab_d = pll_locked ? (stab_q + 24'd1) : 24'd0;
        end
      end
      ST_DONE, ST_ERR: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        write_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      stab_q  <= 24'd0;
      cfg_q   <= '0;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PLL_CFG_VERIFY_EN
      read_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stab_q  <= stab_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PLL_CFG_VERIFY_EN
      read_q  <= read_d;
`endif
    end
  end

  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
  assign mgmt_write     = write_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
